// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bus of the data-memory arbiter.
// The arbiter uses the slave modport; the bench (requesters plus memory model) uses master.
interface dmem_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [3:0]  size;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  modport master (
    output req, we, size, addr, wdata, dmem_rd,
    input  gnt, rvalid, rdata, err, dmem_we, dmem_a, dmem_wd
  );

  modport slave (
    input  req, we, size, addr, wdata, dmem_rd,
    output gnt, rvalid, rdata, err, dmem_we, dmem_a, dmem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, one access per two cycles.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; default is fixed priority (requester 0).
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic        win_q, win_d;
  logic        err_pend_q, err_pend_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [3:0]  dmem_we_q, dmem_we_d;
  logic [31:0] dmem_a_q, dmem_a_d;
  logic [31:0] dmem_wd_q, dmem_wd_d;

  logic        win_s;
  logic        sel_we_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_err_s;

  function automatic logic access_err(input logic [1:0] sz, input logic [31:0] a);
    logic bad;
    case (sz)
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      2'b10:   bad = (a[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad | ({2'b00, a[31:2]} >= DEPTH_LIM);
  endfunction

  function automatic logic [3:0] write_lanes(input logic [1:0] sz);
    logic [3:0] lanes;
    case (sz)
      2'b00:   lanes = 4'b0001;
      2'b01:   lanes = 4'b0011;
      2'b10:   lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;
  // On a tie the requester not granted last time wins.
  assign win_s = (bus.req == 2'b11) ? ~last_q : bus.req[1];
`else
  assign win_s = ~bus.req[0];
`endif

  assign sel_we_s    = bus.we[win_s];
  assign sel_size_s  = win_s ? bus.size[3:2]    : bus.size[1:0];
  assign sel_addr_s  = win_s ? bus.addr[63:32]  : bus.addr[31:0];
  assign sel_wdata_s = win_s ? bus.wdata[63:32] : bus.wdata[31:0];
  assign sel_err_s   = access_err(sel_size_s, sel_addr_s);

  // Next-state and next-output logic; all outputs default to their idle values.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    err_pend_d = err_pend_q;
    gnt_d      = 2'b00;
    rvalid_d   = 2'b00;
    rdata_d    = 32'h0000_0000;
    err_d      = 1'b0;
    dmem_we_d  = 4'b0000;
    dmem_a_d   = 32'h0000_0000;
    dmem_wd_d  = 32'h0000_0000;
`ifdef DMEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (|bus.req) begin
          // Latching here commits the access; it completes even if req drops.
          state_d        = ACCESS;
          win_d          = win_s;
          err_pend_d     = sel_err_s;
          gnt_d[win_s]   = 1'b1;
          dmem_a_d       = sel_addr_s;
          dmem_wd_d      = sel_wdata_s;
          dmem_we_d      = (sel_we_s && !sel_err_s) ? write_lanes(sel_size_s) : 4'b0000;
`ifdef DMEM_ARB_RR_EN
          last_d         = win_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d         = RESP;
        rvalid_d[win_q] = 1'b1;
        rdata_d         = err_pend_q ? 32'h0000_0000 : bus.dmem_rd;
        err_d           = err_pend_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset also kills any pending write at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      err_pend_q <= 1'b0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      rdata_q    <= 32'h0000_0000;
      err_q      <= 1'b0;
      dmem_we_q  <= 4'b0000;
      dmem_a_q   <= 32'h0000_0000;
      dmem_wd_q  <= 32'h0000_0000;
`ifdef DMEM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      err_pend_q <= err_pend_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      dmem_we_q  <= dmem_we_d;
      dmem_a_q   <= dmem_a_d;
      dmem_wd_q  <= dmem_wd_d;
`ifdef DMEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.dmem_we = dmem_we_q;
  assign bus.dmem_a  = dmem_a_q;
  assign bus.dmem_wd = dmem_wd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single accesses, then tie, reset-in-ACCESS sequences.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH_WORDS(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // 64-word memory: combinational read, lane-enabled write on the rising edge.
  logic [31:0] mem [64] = '{default: 32'h0000_0000};
  assign bus.dmem_rd = mem[bus.dmem_a[7:2]];
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bus.dmem_we[l]) mem[bus.dmem_a[7:2]][8*l +: 8] <= bus.dmem_wd[8*l +: 8];
    end
  end

  typedef struct {
    logic        who;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  e_we;
    logic        e_err;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    logic [1:0] onehot;
    onehot = v.who ? 2'b10 : 2'b01;
    @(negedge clk);
    bus.req   = onehot;
    bus.we    = v.who ? {v.we, ~v.we} : {~v.we, v.we};
    bus.size  = v.who ? {v.sz, ~v.sz} : {~v.sz, v.sz};
    bus.addr  = v.who ? {v.a, ~v.a} : {~v.a, v.a};
    bus.wdata = v.who ? {v.w, ~v.w} : {~v.w, v.w};
    @(posedge clk);
    #1;
    chk({nm, " gnt"}, 32'(bus.gnt), 32'(onehot));
    chk({nm, " dmem_we"}, 32'(bus.dmem_we), 32'(v.e_we));
    chk({nm, " dmem_a"}, bus.dmem_a, v.a);
    chk({nm, " dmem_wd"}, bus.dmem_wd, v.w);
    chk({nm, " rvalid@access"}, 32'(bus.rvalid), 32'h0);
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    chk({nm, " rvalid"}, 32'(bus.rvalid), 32'(onehot));
    chk({nm, " err"}, 32'(bus.err), 32'(v.e_err));
    chk({nm, " gnt@resp"}, 32'(bus.gnt), 32'h0);
    chk({nm, " dmem_we@resp"}, 32'(bus.dmem_we), 32'h0);
    if (v.chk_rd) chk({nm, " rdata"}, bus.rdata, v.e_rd);
    @(posedge clk);
  endtask

  initial begin
    logic exp_win [4];
    logic gw [4];
    int   gcyc [4];
    int   ng;
    vec_t rv;

    // who, we, sz, addr, wdata, exp dmem_we, exp err, check rdata, exp rdata
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 32'h08,  32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h08,  32'h0,        4'b0000, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 32'h06,  32'h0000ABCD, 4'b0011, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 2'b10, 32'h04,  32'h0,        4'b0000, 1'b0, 1'b1, 32'h0000ABCD};
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 32'h0C,  32'h12345678, 4'b0001, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 32'h0C,  32'h0,        4'b0000, 1'b0, 1'b1, 32'h00000078};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h0D,  32'h0,        4'b0000, 1'b0, 1'b1, 32'h00000078};
    vecs[7]  = '{1'b0, 1'b0, 2'b10, 32'h0A,  32'h0,        4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 32'h09,  32'h0,        4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 32'h02,  32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 32'h03,  32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 2'b11, 32'h00,  32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 2'b10, 32'h100, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 2'b10, 32'hFC,  32'h0A0B0C0D, 4'b1111, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 2'b10, 32'h00,  32'h0,        4'b0000, 1'b0, 1'b1, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 2'b10, 32'hFC,  32'h0,        4'b0000, 1'b0, 1'b1, 32'h0A0B0C0D};

    bus.req = 2'b00; bus.we = 2'b00; bus.size = 4'h0;
    bus.addr = 64'h0; bus.wdata = 64'h0;

    #12;
    chk("rst gnt", 32'(bus.gnt), 32'h0);
    chk("rst rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst rdata", bus.rdata, 32'h0);
    chk("rst err", 32'(bus.err), 32'h0);
    chk("rst dmem_we", 32'(bus.dmem_we), 32'h0);
    chk("rst dmem_a", bus.dmem_a, 32'h0);
    chk("rst dmem_wd", bus.dmem_wd, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Both requesters held high: observe four grants and their spacing.
`ifdef DMEM_ARB_RR_EN
    exp_win = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_win = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    ng = 0;
    @(negedge clk);
    bus.req = 2'b11; bus.we = 2'b00; bus.size = 4'b1010;
    bus.addr = {32'h04, 32'h08}; bus.wdata = 64'h0;
    for (int c = 0; c < 24 && ng < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.gnt != 2'b00) begin
        chk("tie gnt onehot", 32'($countones(bus.gnt)), 32'd1);
        gw[ng] = bus.gnt[1];
        gcyc[ng] = c;
        ng++;
      end
      if (bus.rvalid != 2'b00) begin
        chk("tie rvalid onehot", 32'($countones(bus.rvalid)), 32'd1);
        chk("tie rdata", bus.rdata, bus.rvalid[1] ? 32'h0000ABCD : 32'hDEADBEEF);
      end
    end
    bus.req = 2'b00;
    chk("tie grant count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) chk($sformatf("tie winner %0d", i), 32'(gw[i]), 32'(exp_win[i]));
    for (int i = 1; i < ng; i++) chk($sformatf("tie spacing %0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd2);
    repeat (3) @(posedge clk);

    // Reset asserted in the ACCESS cycle of a store.
    @(negedge clk);
    bus.req = 2'b01; bus.we = 2'b01; bus.size = 4'b0010;
    bus.addr = {32'h0, 32'h10}; bus.wdata = {32'h0, 32'h55AA55AA};
    @(posedge clk);
    #1;
    chk("rst-acc dmem_we before", 32'(bus.dmem_we), 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst-acc dmem_we", 32'(bus.dmem_we), 32'h0);
    chk("rst-acc gnt", 32'(bus.gnt), 32'h0);
    chk("rst-acc dmem_a", bus.dmem_a, 32'h0);
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    chk("rst-acc rvalid", 32'(bus.rvalid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst rvalid", 32'(bus.rvalid), 32'h0);
    chk("post-rst gnt", 32'(bus.gnt), 32'h0);
    rv = '{1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0};
    run_vec("post-rst load", rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
